// File: rtl/gray_sweep_hazard_checker.sv
// Gray-code sweep driver that counts cone-output toggles per held vector and logs hazardous steps.
// Define GRAY_SWEEP_RETURN_EN to add the descending return sweep (S = 2N-1 instead of N).
module gray_sweep_hazard_checker #(
  parameter int M      = 3,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic [M-1:0]     gray_out,
  output logic             busy,
  output logic             done,
  output logic             hazard,
  output logic [CNT_W-1:0] hazard_count,
  output logic [M:0]       first_step,
  output logic [M-1:0]     first_code,
  output logic             dbg_state
);

  localparam int N = 1 << M;
`ifdef GRAY_SWEEP_RETURN_EN
  localparam int S = 2 * N - 1;
`else
  localparam int S = N;
`endif
  localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;

  typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

  state_t           r_state;
  logic [M:0]       r_step;
  logic [SW-1:0]    r_cyc;
  logic [1:0]       r_tog;
  logic             r_prev;
  logic [M-1:0]     r_gray;
  logic             r_busy;
  logic             r_done;
  logic             r_hazard;
  logic [CNT_W-1:0] r_count;
  logic [M:0]       r_first_step;
  logic [M-1:0]     r_first_code;

  logic [1:0]       w_tog;
  logic             w_step_end;
  logic             w_last;
  logic [M:0]       w_next_step;
  logic [M-1:0]     w_next_code;

  function automatic logic [M-1:0] code_of(input logic [M:0] s);
    logic [M:0] b;
`ifdef GRAY_SWEEP_RETURN_EN
    // Past the top of the ascending half, mirror the step back down toward 0.
    if (s < (M+1)'(N)) b = s;
    else               b = (M+1)'(2 * N - 2) - s;
`else
    b = s;
`endif
    return M'(b ^ (b >> 1));
  endfunction

  always_comb begin
    w_tog       = r_tog;
    if ((dut_out ^ r_prev) && (r_tog != 2'd3)) w_tog = r_tog + 2'd1;
    w_step_end  = (r_cyc == SW'(SETTLE - 1));
    w_last      = (r_step == (M+1)'(S - 1));
    w_next_step = r_step + (M+1)'(1);
    w_next_code = code_of(w_next_step);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_step       <= '0;
      r_cyc        <= '0;
      r_tog        <= '0;
      r_prev       <= 1'b0;
      r_gray       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hazard     <= 1'b0;
      r_count      <= '0;
      r_first_step <= '0;
      r_first_code <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= ST_DRIVE;
            r_busy       <= 1'b1;
            r_gray       <= code_of('0);
            r_step       <= '0;
            r_cyc        <= '0;
            r_tog        <= '0;
            r_prev       <= dut_out;
            r_hazard     <= 1'b0;
            r_count      <= '0;
            r_first_step <= '0;
            r_first_code <= '0;
          end
        end
        ST_DRIVE: begin
          r_prev <= dut_out;
          if (w_step_end) begin
            r_cyc <= '0;
            r_tog <= '0;
            // The sample taken on the closing edge still belongs to this step.
            if (w_tog[1]) begin
              r_hazard <= 1'b1;
              if (r_count != '1) r_count <= r_count + CNT_W'(1);
              if (!r_hazard) begin
                r_first_step <= r_step;
                r_first_code <= r_gray;
              end
            end
            if (w_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_gray  <= '0;
            end else begin
              r_step <= w_next_step;
              r_gray <= w_next_code;
            end
          end else begin
            r_cyc <= r_cyc + SW'(1);
            r_tog <= w_tog;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gray_out     = r_gray;
  assign busy         = r_busy;
  assign done         = r_done;
  assign hazard       = r_hazard;
  assign hazard_count = r_count;
  assign first_step   = r_first_step;
  assign first_code   = r_first_code;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_gray_sweep_hazard_checker.sv
// Scoreboard bench: driver pushes the expected sweep result per launch; a monitor pops on done.
// A second instance with CNT_W = 2 shares all stimulus to exercise counter saturation.
module tb_gray_sweep_hazard_checker;
  localparam int M = 3;
  localparam int SETTLE = 4;
`ifdef GRAY_SWEEP_RETURN_EN
  localparam int S = 15;
`else
  localparam int S = 8;
`endif
  localparam int EW = 29;

  // Handshake: start is accepted on an edge where the DUT is idle; done is a one-cycle
  // pulse after which the result fields are stable until the next accepted start.

  logic clk = 1'b0;
  logic rst_n, start, dut_drv, use_dly, d_dly;
  logic dut_out;
  logic [M-1:0] gray_out, gray2;
  logic busy, done, hazard, busy2, done2, hazard2, dbg1, dbg2;
  logic [7:0] hazard_count;
  logic [1:0] count2;
  logic [M:0] first_step, fs2;
  logic [M-1:0] first_code, fc2;

  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) d_dly <= gray_out[0];
  assign dut_out = use_dly ? d_dly : dut_drv;

  gray_sweep_hazard_checker #(.M(M), .SETTLE(SETTLE), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .gray_out(gray_out), .busy(busy), .done(done), .hazard(hazard),
    .hazard_count(hazard_count), .first_step(first_step), .first_code(first_code),
    .dbg_state(dbg1));

  gray_sweep_hazard_checker #(.M(M), .SETTLE(SETTLE), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .gray_out(gray2), .busy(busy2), .done(done2), .hazard(hazard2),
    .hazard_count(count2), .first_step(fs2), .first_code(fc2),
    .dbg_state(dbg2));

  function automatic logic [2:0] code_of(input int s);
    logic [3:0] b;
`ifdef GRAY_SWEEP_RETURN_EN
    b = (s < 8) ? 4'(s) : 4'(14 - s);
`else
    b = 4'(s);
`endif
    return 3'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] mask);
    int pop = 0;
    int first = -1;
    logic [7:0] c1;
    logic [1:0] c2;
    logic [3:0] fs;
    logic [2:0] fc;
    for (int s = 0; s < S; s++) begin
      if (mask[s]) begin
        pop++;
        if (first < 0) first = s;
      end
    end
    c1 = (pop > 255) ? 8'd255 : 8'(pop);
    c2 = (pop > 3) ? 2'd3 : 2'(pop);
    fs = (first < 0) ? 4'd0 : 4'(first);
    fc = (first < 0) ? 3'd0 : code_of(first);
    exp_q.push_back({pop > 0, c1, c2, fs, fc, 8'(S * SETTLE), code_of(S - 1)});
  endtask

  // Caller is at a negedge; returns at the negedge following the done edge.
  task automatic sweep(input logic [15:0] mask, input bit keep);
    start = 1'b1;
    dut_drv = 1'b0;
    push_exp(mask);
    @(posedge clk);
    for (int idx = 0; idx < S * SETTLE; idx++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      dut_drv = mask[idx / SETTLE] && (idx % SETTLE == 1);
    end
    @(negedge clk);
    dut_drv = 1'b0;
    if (!keep) start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_gray"}, int'(gray_out), 0);
    chk({tag, "_hazard"}, int'(hazard), 0);
    chk({tag, "_count"}, int'(hazard_count), 0);
    chk({tag, "_first_step"}, int'(first_step), 0);
    chk({tag, "_first_code"}, int'(first_code), 0);
    chk({tag, "_count2"}, int'(count2), 0);
  endtask

  // Monitor: checks each driven vector and pops one expectation per done pulse.
  int busy_cnt = 0;
  logic [2:0] last_gray = '0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (busy === 1'b1) begin
      chk("gray_vector", int'(gray_out), int'(code_of(busy_cnt / SETTLE)));
      last_gray = gray_out;
      busy_cnt++;
    end else if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("hazard", int'(hazard), int'(e[28]));
        chk("hazard_count", int'(hazard_count), int'(e[27:20]));
        chk("hazard_count_sat2", int'(count2), int'(e[19:18]));
        chk("first_step", int'(first_step), int'(e[17:14]));
        chk("first_code", int'(first_code), int'(e[13:11]));
        chk("busy_cycles", busy_cnt, int'(e[10:3]));
        chk("last_vector", int'(last_gray), int'(e[2:0]));
        chk("gray_idle", int'(gray_out), 0);
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dut_drv = 1'b0;
    use_dly = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    use_dly = 1'b1;
    sweep(16'h0000, 1'b0);
    use_dly = 1'b0;
    sweep(16'h0020, 1'b0);
    sweep(16'h0204, 1'b0);

    start = 1'b1;
    @(posedge clk);
    for (int idx = 0; idx < 19; idx++) begin
      @(negedge clk);
      dut_drv = (idx == 9);
    end
    @(negedge clk);
    dut_drv = 1'b0;
    chk("midsweep_hazard", int'(hazard), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle("midsweep_reset");
    rst_n = 1'b1;
    sweep(16'h0000, 1'b0);

    sweep(16'hffff, 1'b0);
    sweep(16'h0001, 1'b1);
    sweep(16'h4080, 1'b0);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
